// File: rtl/if_pkg.sv
// Shared types and sizing helpers for the instruction-fetch stage.
package if_pkg;

  localparam int IF_ADDR_W     = 16;
  localparam int IF_INSTR_W    = 16;
  localparam int IF_FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W    = $clog2(IF_FIFO_DEPTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Occupancy counter width for a FIFO holding 0..depth entries.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push and pop may coincide at any occupancy.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int WIDTH = IF_ADDR_W + IF_INSTR_W,
  parameter int DEPTH = IF_FIFO_DEPTH,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC owner, 1-cycle ROM driver, PC-tagged output buffer with
// credit-based issue, stall back-pressure and redirect/flush.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int INSTR_W = IF_INSTR_W,
  parameter int FIFO_DEPTH = IF_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_ren,
  output logic               rom_cen,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int CW1   = CNT_W + 1;
  localparam logic [CW1-1:0] DEPTH_C = CW1'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t           state;
  logic [ADDR_W-1:0] pc, issued_pc;
  logic             inflight, kill;
  logic [CNT_W-1:0] count;
  logic [CW1-1:0]   credits_used;
  logic             go, issue, push, pop, empty;
  entry_t           push_entry, head;

  assign empty     = (count == '0);
  assign out_valid = !reset && !empty && !redirect_valid;
  assign pop       = out_valid && out_ready;

  // Occupancy after this cycle's pop plus the read whose data lands this cycle.
  assign credits_used = {1'b0, count} - CW1'(pop) + CW1'(inflight);

  // An IDLE cycle that sees fetch_en counts as the first RUN cycle, so the
  // first read is not delayed by the state transition.
  assign go    = (state == RUN) || (state == IDLE && fetch_en);
  assign issue = !reset && fetch_en && go && !redirect_valid && (credits_used < DEPTH_C);

  assign rom_ren  = issue;
  assign rom_cen  = issue;
  assign rom_addr = reset ? RESET_PC : pc;

  assign push       = !reset && inflight && !kill && !redirect_valid;
  assign push_entry = '{pc: issued_pc, instr: rom_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
      kill      <= 1'b0;
    end else begin
      state    <= fetch_en ? RUN : IDLE;
      inflight <= issue;
      kill     <= redirect_valid && inflight;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc        <= pc + PC_STEP;
        issued_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH(ADDR_W + INSTR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign out_instr = reset ? '0 : head.instr;
  assign out_pc    = reset ? '0 : head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: start-up latency, stall, redirect, fetch_en
// gaps, PC wrap and mid-stream reset.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        fetch_en, redirect_valid, rom_ren, rom_cen, out_valid, out_ready;
  logic [15:0] redirect_pc, rom_addr, rom_data, out_instr, out_pc;

  logic        b_fetch_en, b_redirect_valid, b_rom_ren, b_rom_cen, b_out_valid, b_out_ready;
  logic [15:0] b_redirect_pc, b_rom_addr, b_rom_data, b_out_instr, b_out_pc;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_ren(rom_ren), .rom_cen(rom_cen), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  if_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clock(clock), .reset(reset), .fetch_en(b_fetch_en),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .rom_addr(b_rom_addr), .rom_ren(b_rom_ren), .rom_cen(b_rom_cen), .rom_data(b_rom_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc)
  );

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return a + 16'h0100;
  endfunction

  // 1-cycle ROMs; garbage when not enabled so stray reads are visible.
  always @(posedge clock) begin
    rom_data   <= rom_ren   ? rom_word(rom_addr)   : 16'hDEAD;
    b_rom_data <= b_rom_ren ? rom_word(b_rom_addr) : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = rom_word(pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(tag, {out_pc, out_instr}, e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    b_fetch_en = 1'b1; b_out_ready = 1'b1; b_redirect_valid = 1'b0; b_redirect_pc = '0;
    tick; tick;

    chk("rst_ren", rom_ren, 0);
    chk("rst_cen", rom_cen, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr_wrap", b_rom_addr, 16'hFFFE);

    reset = 1'b0; #1;
    chk("c0_ren", rom_ren, 1);
    chk("c0_cen", rom_cen, 1);
    chk("c0_addr", rom_addr, 0);
    chk("c0_valid", out_valid, 0);
    tick;
    chk("c1_valid", out_valid, 0);
    chk("c1_addr", rom_addr, 1);
    tick;

    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("seq%0d", k), 16'(k));
      if (k < 3) begin
        w = 16'hFFFE + 16'(k);
        chk($sformatf("wrap_pc%0d", k), b_out_pc, w);
        chk($sformatf("wrap_instr%0d", k), b_out_instr, rom_word(w));
      end
      tick;
    end

    out_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("stall%0d", k), 16'd4);
      chk($sformatf("stall_ren%0d", k), rom_ren, 0);
      tick;
    end
    out_ready = 1'b1; #1;
    chk("resume_ren", rom_ren, 1);
    chk("resume_addr", rom_addr, 6);
    chk_out("resume_head", 16'd4);
    tick; chk_out("resume5", 16'd5);
    tick; chk_out("resume6", 16'd6);
    tick; chk_out("resume7", 16'd7);

    redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
    chk("redir_valid", out_valid, 0);
    chk("redir_ren", rom_ren, 0);
    tick; redirect_valid = 1'b0; #1;
    chk("redir_c1_valid", out_valid, 0);
    chk("redir_c1_ren", rom_ren, 1);
    chk("redir_c1_addr", rom_addr, 16'h0040);
    tick; chk("redir_c2_valid", out_valid, 0);
    tick; chk_out("redir_head", 16'h0040);
    tick; chk_out("redir41", 16'h0041);
    tick; chk_out("redir42", 16'h0042);

    fetch_en = 1'b0; #1;
    chk("fe_off0_ren", rom_ren, 0);
    chk_out("fe_off0", 16'h0042);
    tick;
    chk("fe_off1_ren", rom_ren, 0);
    chk_out("fe_off1_inflight", 16'h0043);
    tick;
    chk("fe_off2_ren", rom_ren, 0);
    chk("fe_off2_valid", out_valid, 0);
    tick; fetch_en = 1'b1; #1;
    chk("fe_on_ren", rom_ren, 1);
    chk("fe_on_addr", rom_addr, 16'h0044);
    tick; chk("fe_on1_valid", out_valid, 0);
    tick; chk_out("fe_on_head", 16'h0044);

    redirect_valid = 1'b1; redirect_pc = 16'h0080; #1;
    chk("b2b0_valid", out_valid, 0);
    tick; redirect_pc = 16'h0090; #1;
    chk("b2b1_valid", out_valid, 0);
    chk("b2b1_ren", rom_ren, 0);
    tick; redirect_valid = 1'b0; #1;
    chk("b2b2_valid", out_valid, 0);
    chk("b2b2_addr", rom_addr, 16'h0090);
    chk("b2b2_ren", rom_ren, 1);
    tick; chk("b2b3_valid", out_valid, 0);
    tick; chk_out("b2b_head", 16'h0090);

    reset = 1'b1; #1;
    tick;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_ren", rom_ren, 0);
    chk("mid_rst_pc", out_pc, 0);
    reset = 1'b0; #1;
    chk("mid_rst_c0_ren", rom_ren, 1);
    chk("mid_rst_c0_addr", rom_addr, 0);
    tick; chk("mid_rst_drop", out_valid, 0);
    tick; chk_out("mid_rst_head", 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
